// File: rtl/instr_loader_if.sv
// Bus bundle for instr_loader: program-load pins, fetch port and status.
//   master : testbench / host side (drives pins and fetch address)
//   slave  : instr_loader side (drives instruction word and status)
//   load_en, data_strobe, data_in : program-load pins
//   fetch_addr                    : instruction fetch byte address
//   instruction_code              : fetched 16-bit word
//   load_busy/done/error          : session state flags
//   byte_count, checksum          : session progress and XOR signature
interface instr_loader_if #(
  parameter int unsigned MEM_BYTES = 32
);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic          load_en;
  logic          data_strobe;
  logic [3:0]    data_in;
  logic [AW-1:0] fetch_addr;
  logic [15:0]   instruction_code;
  logic          load_busy;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   byte_count;
  logic [7:0]    checksum;

  modport master (
    output load_en, data_strobe, data_in, fetch_addr,
    input  instruction_code, load_busy, load_done, load_error, byte_count, checksum
  );

  modport slave (
    input  load_en, data_strobe, data_in, fetch_addr,
    output instruction_code, load_busy, load_done, load_error, byte_count, checksum
  );
endinterface

// File: rtl/instr_loader.sv
// Nibble-serial program loader into a small byte memory with a 16-bit
// instruction fetch port.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : instr_loader_if.slave (pins, fetch address, word and status)
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to build the running
// XOR checksum of loaded bytes; otherwise checksum reads constant 0.
module instr_loader #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic          clk,
  input  logic          reset,
  instr_loader_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t        state, state_n;
  logic          sync1, sync2, sync2_d;
  logic          strobe_evt;
  logic          phase, phase_n;
  logic [3:0]    low_nib, low_nib_n;
  logic [CW-1:0] count, count_n;
  logic          wr_en;
  logic [7:0]    wr_byte;
  logic [7:0]    mem [MEM_BYTES];
  logic [15:0]   instr_q;
  logic [AW-1:0] rd_lo, rd_hi;

  // Strobe pin synchronizer plus edge detector on the second flop
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= bus.data_strobe;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign strobe_evt = sync2 & ~sync2_d;

  // State and session registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      low_nib <= 4'h0;
      count   <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      low_nib <= low_nib_n;
      count   <= count_n;
    end
  end

  // Next-state logic; a coincident strobe is accepted before load_en is judged
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    low_nib_n = low_nib;
    count_n   = count;
    wr_en     = 1'b0;
    wr_byte   = {bus.data_in, low_nib};
    case (state)
      IDLE: begin
        if (bus.load_en) begin
          state_n = LOAD;
          phase_n = 1'b0;
          count_n = '0;
        end
      end
      LOAD: begin
        if (strobe_evt) begin
          if (!phase) begin
            low_nib_n = bus.data_in;
            phase_n   = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_n = count + CW'(1);
            phase_n = 1'b0;
            if (count == CW'(MEM_BYTES - 1)) state_n = DONE;
          end
        end
        if (!bus.load_en && state_n == LOAD) begin
          state_n = phase_n ? ERR : DONE;
          phase_n = 1'b0;
        end
      end
      DONE, ERR: begin
        if (!bus.load_en) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte memory; cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[count[AW-1:0]] <= wr_byte;
    end
  end

  // Word fetch: even byte low, next byte high; forced to zero while loading
  assign rd_lo = bus.fetch_addr & ~AW'(1);
  assign rd_hi = bus.fetch_addr | AW'(1);

  always_ff @(posedge clk) begin
    if (reset) instr_q <= 16'h0000;
    else if (state == LOAD) instr_q <= 16'h0000;
    else instr_q <= {mem[rd_hi], mem[rd_lo]};
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR, cleared on session entry, held through DONE/ERR
  always_ff @(posedge clk) begin
    if (reset) csum <= 8'h00;
    else if (state == IDLE && bus.load_en) csum <= 8'h00;
    else if (wr_en) csum <= csum ^ wr_byte;
  end

  assign bus.checksum = csum;
`else
  assign bus.checksum = 8'h00;
`endif

  assign bus.instruction_code = instr_q;
  assign bus.load_busy        = (state == LOAD);
  assign bus.load_done        = (state == DONE);
  assign bus.load_error       = (state == ERR);
  assign bus.byte_count       = count;
endmodule
